// File: rtl/xcorr_pkg.sv
// xcorr_pkg: shared state encoding, sizing default and config-word field positions
package xcorr_pkg;

    localparam int NFFT_LOG2_DEF  = 10;
    localparam int CONF_FWD_BIT   = 0;
    localparam int CONF_SCALE_LSB = 1;

    typedef enum logic [1:0] {
        IDLE,
        CONFIG,
        LOAD,
        DRAIN
    } state_t;

endpackage

// File: rtl/xcorr_frame_cnt.sv
// xcorr_frame_cnt: wrapping beat counter that flags its all-ones terminal count
module xcorr_frame_cnt #(
    parameter int W = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_tc
);

    logic [W-1:0] r_cnt;

    // clear dominates increment; natural wrap from all-ones back to zero
    always_ff @(posedge clk)
        r_cnt <= (rst || i_clr) ? '0 : i_inc ? r_cnt + 1'b1 : r_cnt;

    assign o_tc = &r_cnt;

endmodule

// File: rtl/xcorr_fft_ctrl.sv
// xcorr_fft_ctrl: sequences config, frame load and output drain around a streaming FFT core
module xcorr_fft_ctrl
    import xcorr_pkg::*;
#(
    parameter int          NFFT_LOG2      = NFFT_LOG2_DEF,
    parameter int          CONF_W         = 8,
    parameter logic [15:0] FRAME_CNT_INIT = 16'h0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CONF_W-1:0] conf_in,
    input  logic              s_val,
    input  logic [31:0]       s_data,
    output logic              s_rdy,
    output logic [CONF_W-1:0] fft_cfg_tdata,
    output logic              fft_cfg_tvalid,
    input  logic              fft_cfg_tready,
    output logic [31:0]       fft_tdata,
    output logic              fft_tvalid,
    input  logic              fft_tready,
    output logic              fft_tlast,
    input  logic              fft_out_val,
    input  logic              fft_out_last,
    output logic              busy,
    output logic              frame_done,
    output logic              len_err,
    output logic [15:0]       frame_cnt
);

    state_t            r_state;
    logic [CONF_W-1:0] r_conf;
    logic              r_cfg_tvalid;
    logic              r_frame_done;
    logic              r_len_err;
    logic [15:0]       r_frame_cnt;
    logic              w_load;
    logic              w_xfer;
    logic              w_in_tc;
    logic              w_out_tc;
    logic              w_out_end;

    assign w_load    = r_state == LOAD;
    assign w_xfer    = fft_tvalid & fft_tready;
    assign w_out_end = fft_out_val & fft_out_last;

    assign s_rdy          = w_load & fft_tready;
    assign fft_tvalid     = w_load & s_val;
    assign fft_tdata      = w_load ? s_data : '0;
    assign fft_tlast      = fft_tvalid & w_in_tc;
    assign fft_cfg_tdata  = r_conf;
    assign fft_cfg_tvalid = r_cfg_tvalid;
    assign busy           = r_state != IDLE;
    assign frame_done     = r_frame_done;
    assign len_err        = r_len_err;
    assign frame_cnt      = r_frame_cnt;

    xcorr_frame_cnt #(.W(NFFT_LOG2)) u_in_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_clr (1'b0),
        .i_inc (w_xfer),
        .o_tc  (w_in_tc)
    );

    xcorr_frame_cnt #(.W(NFFT_LOG2)) u_out_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_out_end),
        .i_inc (fft_out_val),
        .o_tc  (w_out_tc)
    );

    // frame sequencer; start is only honoured from IDLE, so a start coinciding with the final output beat is dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_conf       <= '0;
            r_cfg_tvalid <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_cnt  <= FRAME_CNT_INIT;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                IDLE: if (start) begin
                    r_conf       <= conf_in;
                    r_cfg_tvalid <= 1'b1;
                    r_state      <= CONFIG;
                end
                CONFIG: if (fft_cfg_tready) begin
                    r_cfg_tvalid <= 1'b0;
                    r_state      <= LOAD;
                end
                LOAD: if (w_xfer && w_in_tc)
                    r_state <= DRAIN;
                DRAIN: if (w_out_end) begin
                    r_frame_done <= 1'b1;
                    r_frame_cnt  <= r_frame_cnt + 16'd1;
                    r_state      <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // sticky length check on the core output: early last, or a beat past N-1 without last
    always_ff @(posedge clk) begin
        if (rst)
            r_len_err <= 1'b0;
        else if ((w_out_end && !w_out_tc) || (fft_out_val && !fft_out_last && w_out_tc))
            r_len_err <= 1'b1;
    end

endmodule
